// File: rtl/vga_pkg.sv
// vga_pkg: shared types and constants for the VGA timing generator.
//   - vga_mode_e : output colour source selection
//   - DEF_*      : default 800x600@72 timing (50 MHz pixel clock)
//   - h_total / v_total : total clocks per line / lines per frame
package vga_pkg;

    typedef enum logic [1:0] {
        VGA_EXT   = 2'd0,
        VGA_BARS  = 2'd1,
        VGA_CHECK = 2'd2,
        VGA_RAMP  = 2'd3
    } vga_mode_e;

    localparam int DEF_H_VISIBLE = 800;
    localparam int DEF_H_FP      = 56;
    localparam int DEF_H_SYNC    = 120;
    localparam int DEF_H_BP      = 64;
    localparam int DEF_V_VISIBLE = 600;
    localparam int DEF_V_FP      = 37;
    localparam int DEF_V_SYNC    = 6;
    localparam int DEF_V_BP      = 23;

    function automatic int h_total(input int visible, input int fp, input int sync, input int bp);
        return visible + fp + sync + bp;
    endfunction

    function automatic int v_total(input int visible, input int fp, input int sync, input int bp);
        return visible + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis (horizontal or vertical).
// Counts 0..TOTAL-1 while en_i is high and wraps to 0.
//   clk_i, rst_i : clock, synchronous active-high reset
//   en_i         : advance the counter this cycle
//   count_o      : current position (register output)
//   wrap_o       : count is at TOTAL-1 and will wrap on this edge
//   visible_o    : count < VISIBLE
//   sync_o       : sync level for the current count, POL when active
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int VISIBLE = DEF_H_VISIBLE,
    parameter int FP      = DEF_H_FP,
    parameter int SYNC    = DEF_H_SYNC,
    parameter int BP      = DEF_H_BP,
    parameter bit POL     = 1'b1,
    parameter int W       = $clog2(h_total(VISIBLE, FP, SYNC, BP))
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o,
    output logic         visible_o,
    output logic         sync_o
);

    localparam int            TOTAL    = h_total(VISIBLE, FP, SYNC, BP);
    localparam int            SYNC_BEG = VISIBLE + FP;
    localparam int            SYNC_END = VISIBLE + FP + SYNC;
    localparam logic [W-1:0]  LAST     = W'(TOTAL - 1);

    logic [W-1:0] count_q, count_d;
    logic         at_last;

    always_comb begin
        at_last = (count_q == LAST);
        count_d = count_q;
        if (en_i) begin
            count_d = at_last ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign wrap_o    = en_i && at_last;
    assign visible_o = (int'(count_q) < VISIBLE);
    assign sync_o    = ((int'(count_q) >= SYNC_BEG) && (int'(count_q) < SYNC_END)) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing plus pixel pipeline.
//   clk_i, rst_i      : pixel clock, synchronous active-high reset
//   mode_i            : 0 external, 1 colour bars, 2 checkerboard, 3 ramp
//   ext_rgb_i         : external {R,G,B}, valid PIX_LAT clocks after its x/y
//   x_o, y_o          : current pixel coordinates (counter registers)
//   req_de_o          : x/y inside the visible area
//   line_start_o      : x == 0
//   frame_start_o     : x == 0 and y == 0
//   rgb_o, hsync_o, vsync_o, de_o : registered outputs, PIX_LAT+1 clocks
//                       behind the x/y that produced them
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE  = DEF_H_VISIBLE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_VISIBLE  = DEF_V_VISIBLE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit HS_POL     = 1'b1,
    parameter bit VS_POL     = 1'b1,
    parameter int COLOR_BITS = 2,
    parameter int PIX_LAT    = 1,
    parameter int CHK_LOG2   = 5,
    localparam int HW        = $clog2(h_total(H_VISIBLE, H_FP, H_SYNC, H_BP)),
    localparam int VW        = $clog2(v_total(V_VISIBLE, V_FP, V_SYNC, V_BP)),
    localparam int RGBW      = 3 * COLOR_BITS
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [1:0]      mode_i,
    input  logic [RGBW-1:0] ext_rgb_i,
    output logic [HW-1:0]   x_o,
    output logic [VW-1:0]   y_o,
    output logic            req_de_o,
    output logic            line_start_o,
    output logic            frame_start_o,
    output logic [RGBW-1:0] rgb_o,
    output logic            hsync_o,
    output logic            vsync_o,
    output logic            de_o
);

    localparam int              BAR_W    = H_VISIBLE / 8;
    localparam logic [HW-1:0]   BAR_LAST = HW'(BAR_W - 1);
    // Single-bit masks select the checkerboard bit; they collapse to 0
    // when the square size exceeds the counter width.
    localparam logic [HW-1:0]   CHK_XM   = HW'(1) << CHK_LOG2;
    localparam logic [VW-1:0]   CHK_YM   = VW'(1) << CHK_LOG2;

    typedef struct packed {
        logic            de;
        logic            hs;
        logic            vs;
        logic            ext;
        logic [RGBW-1:0] pat;
    } pix_t;

    localparam pix_t PIX_IDLE = '{de: 1'b0, hs: ~HS_POL, vs: ~VS_POL, ext: 1'b0, pat: '0};

    // ---------------- counters ----------------
    logic h_wrap, h_vis, h_sync;
    logic v_wrap, v_vis, v_sync;

    vga_axis_counter #(
        .VISIBLE(H_VISIBLE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .W(HW)
    ) u_h (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(1'b1),
        .count_o(x_o), .wrap_o(h_wrap), .visible_o(h_vis), .sync_o(h_sync)
    );

    vga_axis_counter #(
        .VISIBLE(V_VISIBLE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .W(VW)
    ) u_v (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(h_wrap),
        .count_o(y_o), .wrap_o(v_wrap), .visible_o(v_vis), .sync_o(v_sync)
    );

    assign req_de_o      = h_vis && v_vis;
    assign line_start_o  = (x_o == '0);
    assign frame_start_o = (x_o == '0) && (y_o == '0);

    // ---------------- mode ----------------
    // v_wrap is only high on the last pixel of the frame, so the new mode
    // becomes active exactly with the next frame's first pixel.
    vga_mode_e mode_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || v_wrap) begin
            mode_q <= vga_mode_e'(mode_i);
        end
    end

    // ---------------- bar counter ----------------
    // Tracks the bar for the current x; bar 7 absorbs the remainder.
    logic [2:0]    bar_q, bar_d;
    logic [HW-1:0] bar_cnt_q, bar_cnt_d;

    always_comb begin
        bar_d     = bar_q;
        bar_cnt_d = bar_cnt_q;
        if (h_wrap) begin
            bar_d     = '0;
            bar_cnt_d = '0;
        end else if (bar_q != 3'd7) begin
            if (bar_cnt_q == BAR_LAST) begin
                bar_d     = bar_q + 1'b1;
                bar_cnt_d = '0;
            end else begin
                bar_cnt_d = bar_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bar_q     <= '0;
            bar_cnt_q <= '0;
        end else begin
            bar_q     <= bar_d;
            bar_cnt_q <= bar_cnt_d;
        end
    end

    // ---------------- pattern / pipeline entry ----------------
    logic [COLOR_BITS-1:0] ramp;
    logic [RGBW-1:0]       pat;
    pix_t                  cur;

    always_comb begin
        ramp = COLOR_BITS'(x_o >> 5);
        pat  = '0;
        unique case (mode_q)
            VGA_BARS:  pat = {{COLOR_BITS{bar_q[2]}}, {COLOR_BITS{bar_q[1]}}, {COLOR_BITS{bar_q[0]}}};
            VGA_CHECK: pat = ((|(x_o & CHK_XM)) ^ (|(y_o & CHK_YM))) ? '1 : '0;
            VGA_RAMP:  pat = {3{ramp}};
            default:   pat = '0;
        endcase
        cur     = PIX_IDLE;
        cur.de  = req_de_o;
        cur.hs  = h_sync;
        cur.vs  = v_sync;
        cur.ext = (mode_q == VGA_EXT);
        cur.pat = pat;
    end

    // Internal patterns, syncs and DE wait PIX_LAT clocks so they line up
    // with ext_rgb_i arriving from the external source.
    pix_t tail;

    generate
        if (PIX_LAT == 0) begin : g_nolat
            assign tail = cur;
        end else begin : g_lat
            pix_t pipe_q [PIX_LAT];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int i = 0; i < PIX_LAT; i++) pipe_q[i] <= PIX_IDLE;
                end else begin
                    pipe_q[0] <= cur;
                    for (int i = 1; i < PIX_LAT; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end

            assign tail = pipe_q[PIX_LAT-1];
        end
    endgenerate

    // ---------------- output register ----------------
    logic [RGBW-1:0] rgb_q;
    logic            hs_q, vs_q, de_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rgb_q <= '0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            de_q  <= 1'b0;
        end else begin
            rgb_q <= !tail.de ? '0 : (tail.ext ? ext_rgb_i : tail.pat);
            hs_q  <= tail.hs;
            vs_q  <= tail.vs;
            de_q  <= tail.de;
        end
    end

    assign rgb_o   = rgb_q;
    assign hsync_o = hs_q;
    assign vsync_o = vs_q;
    assign de_o    = de_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. Three instances share one clock:
//   A: default 800x600 timing, PIX_LAT=1 (hsync, bars, ramp, mid-line reset)
//   B: small frame 56x26, low-active syncs, PIX_LAT=3 (external source
//      alignment, frame-synchronous switch to checkerboard, reset)
//   C: tiny frame 14x7 (simultaneous line/frame wrap, DE count)
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instance A ----------------
    logic        a_rst;
    logic [1:0]  a_mode;
    logic [5:0]  a_ext;
    logic [10:0] a_x;
    logic [9:0]  a_y;
    logic        a_req, a_ls, a_fs, a_hs, a_vs, a_de;
    logic [5:0]  a_rgb;

    vga_timing_gen u_a (
        .clk_i(clk), .rst_i(a_rst), .mode_i(a_mode), .ext_rgb_i(a_ext),
        .x_o(a_x), .y_o(a_y), .req_de_o(a_req), .line_start_o(a_ls), .frame_start_o(a_fs),
        .rgb_o(a_rgb), .hsync_o(a_hs), .vsync_o(a_vs), .de_o(a_de)
    );

    // ---------------- instance B ----------------
    logic       b_rst;
    logic [1:0] b_mode;
    logic [5:0] b_ext;
    logic [5:0] b_x;
    logic [4:0] b_y;
    logic       b_req, b_ls, b_fs, b_hs, b_vs, b_de;
    logic [5:0] b_rgb;

    vga_timing_gen #(
        .H_VISIBLE(40), .H_FP(4), .H_SYNC(4), .H_BP(8),
        .V_VISIBLE(20), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LAT(3)
    ) u_b (
        .clk_i(clk), .rst_i(b_rst), .mode_i(b_mode), .ext_rgb_i(b_ext),
        .x_o(b_x), .y_o(b_y), .req_de_o(b_req), .line_start_o(b_ls), .frame_start_o(b_fs),
        .rgb_o(b_rgb), .hsync_o(b_hs), .vsync_o(b_vs), .de_o(b_de)
    );

    // ---------------- instance C ----------------
    logic       c_rst;
    logic [1:0] c_mode;
    logic [5:0] c_ext;
    logic [3:0] c_x;
    logic [2:0] c_y;
    logic       c_req, c_ls, c_fs, c_hs, c_vs, c_de;
    logic [5:0] c_rgb;

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_c (
        .clk_i(clk), .rst_i(c_rst), .mode_i(c_mode), .ext_rgb_i(c_ext),
        .x_o(c_x), .y_o(c_y), .req_de_o(c_req), .line_start_o(c_ls), .frame_start_o(c_fs),
        .rgb_o(c_rgb), .hsync_o(c_hs), .vsync_o(c_vs), .de_o(c_de)
    );

    // External pixel source for B: a colour derived from the coordinates.
    function automatic logic [5:0] fext(input int x, input int y);
        return 6'(x * 5 + y * 3);
    endfunction

    // Expected {de, hs, vs, rgb} of B in cycle t after release. Outputs lag
    // 4 clocks; frame 0 is external, frame 1 onward is the checkerboard.
    function automatic logic [8:0] exp_b(input int t);
        int p, px, py;
        logic vis, hs, vs;
        logic [5:0] rgb;
        if (t < 4) return {1'b0, 1'b1, 1'b1, 6'h00};
        p   = t - 4;
        px  = p % 56;
        py  = (p / 56) % 26;
        vis = (px < 40) && (py < 20);
        hs  = !((px >= 44) && (px < 48));
        vs  = !((py >= 22) && (py < 24));
        if (!vis)          rgb = 6'h00;
        else if (p < 1456) rgb = fext(px, py);
        else               rgb = ((((px >> 5) ^ (py >> 5)) & 1) != 0) ? 6'h3F : 6'h00;
        return {vis, hs, vs, rgb};
    endfunction

    int hx [3000];
    int hy [3000];

    // Bars: cycle t shows x = t-2 on line 0.
    int         bar_t [8] = '{2, 52, 102, 552, 601, 602, 801, 802};
    logic [5:0] bar_e [8] = '{6'h00, 6'h00, 6'h03, 6'h33, 6'h33, 6'h3C, 6'h3F, 6'h00};
    // Ramp: channel value = x[6:5].
    int         rmp_t [6] = '{33, 42, 66, 102, 737, 802};
    logic [5:0] rmp_e [6] = '{6'h00, 6'h15, 6'h2A, 6'h3F, 6'h2A, 6'h00};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise0, rise1, fall0, k, dc0, dc1;
        logic prev_hs;

        a_rst = 1'b1; a_mode = 2'd1; a_ext = '0;
        b_rst = 1'b1; b_mode = 2'd0; b_ext = '0;
        c_rst = 1'b1; c_mode = 2'd0; c_ext = '0;

        // ================= A: default timing, bars =================
        repeat (3) tick();
        chk("a_rst_x",   a_x,   0);
        chk("a_rst_y",   a_y,   0);
        chk("a_rst_de",  a_de,  0);
        chk("a_rst_hs",  a_hs,  0);
        chk("a_rst_vs",  a_vs,  0);
        chk("a_rst_rgb", a_rgb, 0);
        a_rst = 1'b0;
        chk("a_fs_first", a_fs, 1);

        rise0 = -1; rise1 = -1; fall0 = -1; prev_hs = a_hs;
        for (int t = 0; t < 2100; t++) begin
            if (a_hs && !prev_hs) begin
                if (rise0 < 0) rise0 = t;
                else if (rise1 < 0) rise1 = t;
            end
            if (!a_hs && prev_hs && fall0 < 0) fall0 = t;
            prev_hs = a_hs;
            for (int i = 0; i < 8; i++)
                if (t == bar_t[i]) chk($sformatf("a_bar_t%0d", t), a_rgb, bar_e[i]);
            if (t == 801) chk("a_de_x799", a_de, 1);
            if (t == 802) chk("a_de_x800", a_de, 0);
            if (t == 1040) begin
                chk("a_line1_x",  a_x,  0);
                chk("a_line1_y",  a_y,  1);
                chk("a_line1_ls", a_ls, 1);
                chk("a_line1_fs", a_fs, 0);
            end
            tick();
        end
        chk("a_hs_rise",   rise0, 858);
        chk("a_hs_width",  fall0 - rise0, 120);
        chk("a_hs_period", rise1 - rise0, 1040);

        // mid-line reset at x=500, then ramp mode from the new frame
        for (k = 0; k < 1100 && a_x != 11'd500; k++) tick();
        chk("a_find_x500", a_x, 500);
        chk("a_de_pre_rst", a_de, 1);
        a_rst = 1'b1; a_mode = 2'd3;
        tick();
        chk("a_mrst_x",  a_x,  0);
        chk("a_mrst_y",  a_y,  0);
        chk("a_mrst_de", a_de, 0);
        chk("a_mrst_hs", a_hs, 0);
        chk("a_mrst_vs", a_vs, 0);
        a_rst = 1'b0;
        chk("a_mrst_fs", a_fs, 1);
        for (int t = 0; t < 805; t++) begin
            for (int i = 0; i < 6; i++)
                if (t == rmp_t[i]) chk($sformatf("a_ramp_t%0d", t), a_rgb, rmp_e[i]);
            tick();
        end

        // ================= B: external source, mode switch =================
        repeat (3) tick();
        chk("b_rst_hs", b_hs, 1);
        chk("b_rst_vs", b_vs, 1);
        chk("b_rst_de", b_de, 0);
        b_rst = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            hx[t] = int'(b_x);
            hy[t] = int'(b_y);
            if (t >= 3) b_ext = fext(hx[t-3], hy[t-3]);
            else        b_ext = '0;
            if (t == 560) b_mode = 2'd2;   // y=10 of frame 0
            if (t % 4 == 0) chk($sformatf("b_out_t%0d", t), {b_de, b_hs, b_vs, b_rgb}, exp_b(t));
            if (t % 728 == 0) chk($sformatf("b_fs_t%0d", t), b_fs, (t % 1456) == 0);
            if (t % 97 == 0) chk($sformatf("b_x_t%0d", t), b_x, t % 56);
            if (t == 1456 + 35) chk("b_chk_x31_y0", b_rgb, 6'h00);
            if (t == 1456 + 36) chk("b_chk_x32_y0", b_rgb, 6'h3F);
            tick();
        end
        for (k = 0; k < 1500 && !(b_x == 6'd30 && b_y == 5'd5); k++) tick();
        chk("b_find_30_5", {b_y, b_x}, {5'd5, 6'd30});
        chk("b_de_pre_rst", b_de, 1);
        b_rst = 1'b1;
        tick();
        chk("b_mrst_x",  b_x,  0);
        chk("b_mrst_y",  b_y,  0);
        chk("b_mrst_de", b_de, 0);
        chk("b_mrst_hs", b_hs, 1);
        chk("b_mrst_vs", b_vs, 1);
        b_rst = 1'b0;

        // ================= C: tiny frame =================
        repeat (2) tick();
        c_rst = 1'b0;
        dc0 = 0; dc1 = 0;
        for (int t = 0; t < 200; t++) begin
            if (t >= 2   && t < 100) dc0 += int'(c_de);
            if (t >= 100 && t < 198) dc1 += int'(c_de);
            if (t == 14) begin
                chk("c_l1_ls", c_ls, 1);
                chk("c_l1_fs", c_fs, 0);
                chk("c_l1_y",  c_y,  1);
            end
            if (t == 97) begin
                chk("c_last_x",  c_x,  13);
                chk("c_last_y",  c_y,  6);
                chk("c_last_ls", c_ls, 0);
            end
            if (t == 98) begin
                chk("c_wrap_x",  c_x,  0);
                chk("c_wrap_y",  c_y,  0);
                chk("c_wrap_ls", c_ls, 1);
                chk("c_wrap_fs", c_fs, 1);
            end
            tick();
        end
        chk("c_de_frame0", dc0, 32);
        chk("c_de_frame1", dc1, 32);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
